// File: rtl/baud_rate_generator.sv
// baud_rate_generator: programmable oversample / baud tick generator.
// Divides clk_in by a runtime-loadable divisor N to produce os_tick, a
// baud_tick on every OS_RATE-th os_tick, and a near-50% duty clk_out.
// Optional build macro FRAC_DIV_EN adds a fractional divisor (frac_in):
// a FRAC_W-bit accumulator stretches an os period to N+1 cycles on carry.
module baud_rate_generator #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 27,
    parameter int OS_RATE     = 16,
    parameter int FRAC_W      = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_clr,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_in,
`ifdef FRAC_DIV_EN
    input  logic [FRAC_W-1:0] frac_in,
`endif
    output logic             div_err,
    output logic [DIV_W-1:0] div_cur,
    output logic             os_tick,
    output logic             baud_tick,
    output logic             clk_out
);

    localparam int              OS_W    = $clog2(OS_RATE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OS_RATE / 2);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] pend_div;
    logic             pend_valid;
    logic [OS_W-1:0]  os_cnt;

    logic             wr_ok;
    logic             pend_any;
    logic [DIV_W-1:0] next_div;
    logic [DIV_W-1:0] term_cnt;
    logic             wrap;
    logic             apply;
    logic [OS_W-1:0]  os_nxt;
    logic             extend;

    // Decode write validity, the terminal count and the divisor-apply point.
    // NOTE: every output of this block is assigned on every pass, so no latch can be inferred.
    always_comb begin
        wr_ok    = div_wr && (div_in != '0);
        pend_any = wr_ok || pend_valid;
        next_div = wr_ok ? div_in : pend_div;
        term_cnt = extend ? div_cur : div_cur - DIV_W'(1);
        // >= rather than == keeps the counter safe if it ever sits past the terminal value.
        wrap     = (div_cnt >= term_cnt);
        apply    = !enable || sync_clr || wrap;
        os_nxt   = (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
    end

    // Divisor bookkeeping, both counters and all registered outputs.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            div_cur    <= DIV_W'(DEFAULT_DIV);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            div_cnt    <= '0;
            os_cnt     <= '0;
            os_tick    <= 1'b0;
            baud_tick  <= 1'b0;
            clk_out    <= 1'b0;
            div_err    <= 1'b0;
        end else begin
            div_err <= div_wr && (div_in == '0);

            // A same-cycle write wins over an older pending value at the apply point.
            if (apply && pend_any) begin
                div_cur    <= next_div;
                pend_valid <= 1'b0;
            end else if (wr_ok) begin
                pend_div   <= div_in;
                pend_valid <= 1'b1;
            end

            if (!enable) begin
                div_cnt   <= '0;
                os_cnt    <= '0;
                os_tick   <= 1'b0;
                baud_tick <= 1'b0;
                clk_out   <= 1'b0;
            end else if (sync_clr) begin
                div_cnt   <= '0;
                os_cnt    <= '0;
                os_tick   <= 1'b0;
                baud_tick <= 1'b0;
                clk_out   <= 1'b1;
            end else if (wrap) begin
                div_cnt   <= '0;
                os_cnt    <= os_nxt;
                os_tick   <= 1'b1;
                baud_tick <= (os_cnt == OS_LAST);
                clk_out   <= (os_nxt < OS_HALF);
            end else begin
                div_cnt   <= div_cnt + DIV_W'(1);
                os_tick   <= 1'b0;
                baud_tick <= 1'b0;
                clk_out   <= (os_cnt < OS_HALF);
            end
        end
    end

`ifdef FRAC_DIV_EN
    logic [FRAC_W-1:0] frac_cur;
    logic [FRAC_W-1:0] frac_pend;
    logic [FRAC_W-1:0] frac_acc;
    logic              extend_r;

    // Fraction tracks the integer divisor's pending/apply path; a carry stretches the next period.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            frac_cur  <= '0;
            frac_pend <= '0;
            frac_acc  <= '0;
            extend_r  <= 1'b0;
        end else begin
            if (apply && pend_any) begin
                frac_cur <= wr_ok ? frac_in : frac_pend;
            end else if (wr_ok) begin
                frac_pend <= frac_in;
            end

            if (!enable || sync_clr) begin
                frac_acc <= '0;
                extend_r <= 1'b0;
            end else if (wrap) begin
                {extend_r, frac_acc} <= {1'b0, frac_acc} + {1'b0, frac_cur};
            end
        end
    end

    assign extend = extend_r;
`else
    // Integer-only build: the fraction is fixed at zero, so the accumulator never carries.
    localparam logic [FRAC_W-1:0] FRAC_ZERO = '0;
    assign extend = (FRAC_ZERO != '0);
`endif

endmodule
